// File: rtl/sid_spi_driver.sv
// SPI mode-0 write master for tt_um_sid: serialises each accepted register write
// as a 16-bit frame {1'b1, 2'b00, addr, data} with programmable SCLK rate and CS guard times.
module sid_spi_driver #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [4:0] i_cmd_addr,
    input  logic [7:0] i_cmd_data,
    output logic       o_spi_clk,
    output logic       o_spi_cs_n,
    output logic       o_spi_mosi,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_t;

    // Phase counters count down to zero, so each load is the phase length minus one.
    localparam logic [15:0] L_SETUP = 16'(CS_SETUP - 1);
    localparam logic [15:0] L_DIV   = 16'(CLK_DIV - 1);
    localparam logic [15:0] L_HOLD  = 16'(CS_HOLD - 1);
    localparam logic [15:0] L_GAP   = 16'(CS_GAP - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic [3:0]  r_bit;
    logic [3:0]  w_bit_nxt;
    logic        r_high;
    logic        w_high_nxt;
    logic [15:0] r_shreg;
    logic [15:0] w_shreg_nxt;
    logic        w_cnt_zero;
    logic        w_cs_active;

    logic        r_cmd_ready;
    logic        r_spi_clk;
    logic        r_spi_cs_n;
    logic        r_spi_mosi;
    logic        r_busy;
    logic        r_done;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_high_nxt  = r_high;
        w_shreg_nxt = r_shreg;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_valid && r_cmd_ready) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = L_SETUP;
                    w_shreg_nxt = {1'b1, 2'b00, i_cmd_addr, i_cmd_data};
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_SHIFT;
                    w_cnt_nxt   = L_DIV;
                    w_high_nxt  = 1'b0;
                    w_bit_nxt   = 4'd15;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_SHIFT: begin
                if (!w_cnt_zero) begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end else if (!r_high) begin
                    w_high_nxt = 1'b1;
                    w_cnt_nxt  = L_DIV;
                end else if (r_bit == 4'd0) begin
                    w_state_nxt = S_HOLD;
                    w_high_nxt  = 1'b0;
                    w_cnt_nxt   = L_HOLD;
                end else begin
                    // Falling edge: present the next bit in the same cycle SCLK drops.
                    w_high_nxt  = 1'b0;
                    w_cnt_nxt   = L_DIV;
                    w_bit_nxt   = r_bit - 4'd1;
                    w_shreg_nxt = {r_shreg[14:0], 1'b0};
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_GAP;
                    w_cnt_nxt   = L_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_cs_active = (w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT) ||
                         (w_state_nxt == S_HOLD);

    // Outputs are registered from the next-state values so the pins change on the same edge as the state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= '0;
            r_high      <= 1'b0;
            r_shreg     <= '0;
            r_cmd_ready <= 1'b0;
            r_spi_clk   <= 1'b0;
            r_spi_cs_n  <= 1'b1;
            r_spi_mosi  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_high      <= w_high_nxt;
            r_shreg     <= w_shreg_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_spi_clk   <= (w_state_nxt == S_SHIFT) && w_high_nxt;
            r_spi_cs_n  <= !w_cs_active;
            r_spi_mosi  <= w_cs_active && w_shreg_nxt[15];
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (r_state == S_HOLD) && (w_state_nxt == S_GAP);
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_spi_clk   = r_spi_clk;
    assign o_spi_cs_n  = r_spi_cs_n;
    assign o_spi_mosi  = r_spi_mosi;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_sid_spi_driver.sv
// Scoreboard bench for sid_spi_driver: one instance with default timing, one with all
// timing parameters at 1; a monitor decodes the SPI lines and checks frames and latencies.
module tb_sid_spi_driver;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] rstN;
    logic [NI-1:0] valid;
    logic [4:0]    addr [NI];
    logic [7:0]    data [NI];
    logic [NI-1:0] ready;
    logic [NI-1:0] sclk;
    logic [NI-1:0] csN;
    logic [NI-1:0] mosi;
    logic [NI-1:0] busy;
    logic [NI-1:0] done;

    logic [15:0] expQ [NI][$];
    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    function automatic int pDiv(input int i);
        return (i == 0) ? 4 : 1;
    endfunction
    function automatic int pSetup(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int pHold(input int i);
        return (i == 0) ? 2 : 1;
    endfunction
    function automatic int pGap(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : gDut
        sid_spi_driver #(
            .CLK_DIV (g == 0 ? 4 : 1),
            .CS_SETUP(g == 0 ? 2 : 1),
            .CS_HOLD (g == 0 ? 2 : 1),
            .CS_GAP  (g == 0 ? 4 : 1)
        ) dut (
            .i_clk      (clk),
            .i_rst_n    (rstN[g]),
            .i_cmd_valid(valid[g]),
            .o_cmd_ready(ready[g]),
            .i_cmd_addr (addr[g]),
            .i_cmd_data (data[g]),
            .o_spi_clk  (sclk[g]),
            .o_spi_cs_n (csN[g]),
            .o_spi_mosi (mosi[g]),
            .o_busy     (busy[g]),
            .o_done     (done[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h",
                     name, inst, cyc, act, exp);
        end
    endtask

    // Monitor state, one slot per instance.
    int          accCyc    [NI];
    int          firstRise [NI];
    int          lastFall  [NI];
    int          rxCount   [NI];
    logic [15:0] rxFrame   [NI];
    bit          inFrame   [NI] = '{1'b0, 1'b0};
    bit          waitReady [NI] = '{1'b0, 1'b0};
    bit          rstPend   [NI] = '{1'b1, 1'b1};
    logic        prevSclk  [NI] = '{1'b0, 1'b0};
    logic        prevCs    [NI] = '{1'b1, 1'b1};
    logic        prevMosi  [NI] = '{1'b0, 1'b0};
    logic        prevReady [NI] = '{1'b0, 1'b0};
    logic [15:0] monExp;

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rstPend[i]) begin
                checkOutput("rstCsN", i, csN[i], 1);
                checkOutput("rstSclk", i, sclk[i], 0);
                checkOutput("rstMosi", i, mosi[i], 0);
                checkOutput("rstReady", i, ready[i], 0);
                checkOutput("rstBusy", i, busy[i], 0);
                checkOutput("rstDone", i, done[i], 0);
                if (inFrame[i] && expQ[i].size() > 0) monExp = expQ[i].pop_front();
                inFrame[i]   = 1'b0;
                waitReady[i] = 1'b0;
            end else begin
                checkOutput("busyInv", i, busy[i], !ready[i]);
                if (csN[i]) begin
                    checkOutput("idleSclk", i, sclk[i], 0);
                    checkOutput("idleMosi", i, mosi[i], 0);
                end
                if (mosi[i] !== prevMosi[i]) checkOutput("mosiChangeSclkLow", i, sclk[i], 0);
                if (sclk[i] && !prevSclk[i]) begin
                    rxFrame[i] = {rxFrame[i][14:0], mosi[i]};
                    rxCount[i]++;
                    if (firstRise[i] < 0) firstRise[i] = cyc;
                end
                if (!sclk[i] && prevSclk[i]) lastFall[i] = cyc;
                if (!prevCs[i] && csN[i]) begin
                    if (expQ[i].size() == 0) begin
                        checkOutput("queueDepth", i, expQ[i].size(), 1);
                    end else begin
                        monExp = expQ[i].pop_front();
                        checkOutput("frame", i, rxFrame[i], monExp);
                        checkOutput("riseCount", i, rxCount[i], 16);
                        checkOutput("doneAtEnd", i, done[i], 1);
                        checkOutput("csLowLen", i, cyc - accCyc[i],
                                    pSetup(i) + 32 * pDiv(i) + pHold(i) + 1);
                        checkOutput("firstRise", i, firstRise[i] - accCyc[i],
                                    1 + pSetup(i) + pDiv(i));
                        checkOutput("holdTime", i, cyc - lastFall[i], pHold(i));
                    end
                    inFrame[i]   = 1'b0;
                    waitReady[i] = 1'b1;
                end else if (done[i]) begin
                    checkOutput("spuriousDone", i, done[i], 0);
                end
                if (ready[i] && !prevReady[i] && waitReady[i]) begin
                    checkOutput("readyLatency", i, cyc - accCyc[i],
                                pSetup(i) + 32 * pDiv(i) + pHold(i) + pGap(i) + 1);
                    waitReady[i] = 1'b0;
                end
                if (inFrame[i] && cyc == accCyc[i] + 1) checkOutput("csFall", i, csN[i], 0);
                if (valid[i] && ready[i]) begin
                    accCyc[i]    = cyc;
                    inFrame[i]   = 1'b1;
                    rxCount[i]   = 0;
                    rxFrame[i]   = '0;
                    firstRise[i] = -1;
                end
            end
            prevSclk[i]  = sclk[i];
            prevCs[i]    = csN[i];
            prevMosi[i]  = mosi[i];
            prevReady[i] = ready[i];
            rstPend[i]   = !rstN[i];
        end
    end

    // Drives one command and pushes its frame once accepted; keep leaves valid high for a follow-on command.
    task automatic applyStimulus(input int i, input logic [4:0] a, input logic [7:0] d,
                                 input bit keep);
        int n = 0;
        valid[i] = 1'b1;
        addr[i]  = a;
        data[i]  = d;
        do begin
            @(negedge clk);
            n++;
        end while (ready[i] !== 1'b1 && n < 1000);
        checkOutput("acceptTimeout", i, ready[i], 1);
        if (ready[i] === 1'b1) expQ[i].push_back(16'h8000 + 16'(a) * 16'd256 + 16'(d));
        @(posedge clk);
        #1;
        if (!keep) begin
            valid[i] = 1'b0;
            addr[i]  = 5'($urandom);
            data[i]  = 8'($urandom);
        end
    endtask

    task automatic waitIdle(input int i);
        int n = 0;
        while ((expQ[i].size() != 0 || ready[i] !== 1'b1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", i, expQ[i].size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset(input int i, input int afterCycles);
        repeat (afterCycles) @(posedge clk);
        #1 rstN[i] = 1'b0;
        @(posedge clk);
        #1 rstN[i] = 1'b1;
    endtask

    initial begin
        rstN  = '0;
        valid = '0;
        for (int i = 0; i < NI; i++) begin
            addr[i] = '0;
            data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rstN = '1;
        @(posedge clk);
        #1;

        applyStimulus(0, 5'h18, 8'h0F, 1'b0);
        waitIdle(0);
        applyStimulus(0, 5'h00, 8'h41, 1'b1);
        applyStimulus(0, 5'h1F, 8'hFF, 1'b0);
        waitIdle(0);

        // Abort during bit 7 of the shift phase, then confirm a clean follow-up frame.
        applyStimulus(0, 5'h0A, 8'h33, 1'b0);
        pulseReset(0, 68);
        applyStimulus(0, 5'h13, 8'hC6, 1'b0);
        waitIdle(0);

        applyStimulus(1, 5'h05, 8'hA5, 1'b1);
        applyStimulus(1, 5'h1A, 8'h5A, 1'b0);
        waitIdle(1);
        applyStimulus(1, 5'($urandom), 8'($urandom), 1'b0);
        pulseReset(1, $urandom_range(1, 30));
        waitIdle(1);

        for (int i = 0; i < NI; i++) begin
            for (int r = 0; r < 6; r++) begin
                bit keep;
                keep = (r < 5) && ($urandom_range(0, 1) == 1);
                applyStimulus(i, 5'($urandom), 8'($urandom), keep);
                if (!keep) repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            waitIdle(i);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
